// File: rtl/zbb_mc_unit.sv
// Multi-cycle Zbb execute unit: registered single-cycle ops plus STEP-bit iterative count/carry-less ops.
// Optional carry-less multiply family enabled by defining ZBB_MC_ZBC_EN.

module zbb_mc_orc_lane (
    input  logic [7:0] byteIn,
    output logic [7:0] orcOut
);
    assign orcOut = (|byteIn) ? 8'hFF : 8'h00;
endmodule

module zbb_mc_unit #(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);
    localparam int ITERS = XLEN / STEP;
    localparam int CW    = $clog2(XLEN + 1);
    localparam int IW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int SHW   = $clog2(XLEN);
    localparam int NB    = XLEN / 8;
    localparam logic [SHW:0] XLENV = (SHW + 1)'(XLEN);

    localparam logic [4:0] OP_ANDN   = 5'd0;
    localparam logic [4:0] OP_ORN    = 5'd1;
    localparam logic [4:0] OP_XNOR   = 5'd2;
    localparam logic [4:0] OP_MIN    = 5'd3;
    localparam logic [4:0] OP_MAX    = 5'd4;
    localparam logic [4:0] OP_MINU   = 5'd5;
    localparam logic [4:0] OP_MAXU   = 5'd6;
    localparam logic [4:0] OP_SEXTB  = 5'd7;
    localparam logic [4:0] OP_SEXTH  = 5'd8;
    localparam logic [4:0] OP_ZEXTH  = 5'd9;
    localparam logic [4:0] OP_ROL    = 5'd10;
    localparam logic [4:0] OP_ROR    = 5'd11;
    localparam logic [4:0] OP_ORCB   = 5'd12;
    localparam logic [4:0] OP_REV8   = 5'd13;
    localparam logic [4:0] OP_CLZ    = 5'd16;
    localparam logic [4:0] OP_CTZ    = 5'd17;
    localparam logic [4:0] OP_CPOP   = 5'd18;
`ifdef ZBB_MC_ZBC_EN
    localparam logic [4:0] OP_CLMUL  = 5'd20;
    localparam logic [4:0] OP_CLMULH = 5'd21;
    localparam logic [4:0] OP_CLMULR = 5'd22;
`endif

    typedef enum logic [1:0] {IDLE, ITER, DONE} stateT;

    typedef struct packed {
        logic            illegal;
        logic [XLEN-1:0] data;
    } respT;

    stateT           state, stateNext;
    respT            respQ;
    logic [4:0]      opQ;
    logic [XLEN-1:0] shReg;
    logic [CW-1:0]   cntQ, cntNext;
    logic            foundQ, foundNext;
    logic [IW-1:0]   iterQ;
    logic            lastIter;
    logic            iterLegal, singleLegal;
    logic            acceptIter, acceptSingle;
    logic [XLEN-1:0] singleRes, iterRes, rs1Rev;
    logic [XLEN-1:0] rolRes, rorRes;
    logic [SHW-1:0]  rotAmt;

    logic [NB-1:0][7:0] rs1Bytes, orcBytes, revBytes;

    assign rs1Bytes = rs1_i;

    for (genvar b = 0; b < NB; b++) begin : gLane
        zbb_mc_orc_lane uOrc (
            .byteIn (rs1Bytes[b]),
            .orcOut (orcBytes[b])
        );
        assign revBytes[b] = rs1Bytes[NB-1-b];
    end

    assign rotAmt = rs2_i[SHW-1:0];
    // Shift by XLEN yields zero, so the zero-amount rotate needs no special case.
    assign rolRes = (rs1_i << rotAmt) | (rs1_i >> (XLENV - {1'b0, rotAmt}));
    assign rorRes = (rs1_i >> rotAmt) | (rs1_i << (XLENV - {1'b0, rotAmt}));

    always_comb begin
        for (int i = 0; i < XLEN; i++) rs1Rev[i] = rs1_i[XLEN-1-i];
    end

    always_comb begin
        singleRes   = '0;
        singleLegal = 1'b1;
        case (op_i)
            OP_ANDN:  singleRes = rs1_i & ~rs2_i;
            OP_ORN:   singleRes = rs1_i | ~rs2_i;
            OP_XNOR:  singleRes = ~(rs1_i ^ rs2_i);
            OP_MIN:   singleRes = ($signed(rs1_i) < $signed(rs2_i)) ? rs1_i : rs2_i;
            OP_MAX:   singleRes = ($signed(rs1_i) < $signed(rs2_i)) ? rs2_i : rs1_i;
            OP_MINU:  singleRes = (rs1_i < rs2_i) ? rs1_i : rs2_i;
            OP_MAXU:  singleRes = (rs1_i < rs2_i) ? rs2_i : rs1_i;
            OP_SEXTB: singleRes = {{(XLEN-8){rs1_i[7]}}, rs1_i[7:0]};
            OP_SEXTH: singleRes = {{(XLEN-16){rs1_i[15]}}, rs1_i[15:0]};
            OP_ZEXTH: singleRes = {{(XLEN-16){1'b0}}, rs1_i[15:0]};
            OP_ROL:   singleRes = rolRes;
            OP_ROR:   singleRes = rorRes;
            OP_ORCB:  singleRes = orcBytes;
            OP_REV8:  singleRes = revBytes;
            default:  singleLegal = 1'b0;
        endcase
    end

    always_comb begin
        iterLegal = 1'b0;
        case (op_i)
            OP_CLZ, OP_CTZ, OP_CPOP: iterLegal = 1'b1;
`ifdef ZBB_MC_ZBC_EN
            OP_CLMUL, OP_CLMULH, OP_CLMULR: iterLegal = 1'b1;
`endif
            default: iterLegal = 1'b0;
        endcase
    end

    assign acceptIter   = (state == IDLE) && valid_i && !flush_i && iterLegal;
    assign acceptSingle = (state == IDLE) && valid_i && !flush_i && !iterLegal;
    assign lastIter     = (iterQ == IW'(ITERS - 1));

    // CTZ is handled as CLZ of the bit-reversed operand; both scan the top STEP bits each cycle.
    always_comb begin
        cntNext   = cntQ;
        foundNext = foundQ;
        for (int j = STEP - 1; j >= 0; j--) begin
            if (opQ == OP_CPOP) begin
                cntNext = cntNext + CW'(shReg[XLEN-STEP+j]);
            end else if (!foundNext) begin
                if (shReg[XLEN-STEP+j]) foundNext = 1'b1;
                else                    cntNext   = cntNext + CW'(1);
            end
        end
    end

`ifdef ZBB_MC_ZBC_EN
    logic [2*XLEN-1:0] mcandQ, clAccQ, clAccNext;
    logic [XLEN-1:0]   mplierQ;

    always_comb begin
        clAccNext = clAccQ;
        for (int j = 0; j < STEP; j++) begin
            if (mplierQ[j]) clAccNext = clAccNext ^ (mcandQ << j);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcandQ  <= '0;
            mplierQ <= '0;
            clAccQ  <= '0;
        end else if (acceptIter) begin
            mcandQ  <= {{XLEN{1'b0}}, rs1_i};
            mplierQ <= rs2_i;
            clAccQ  <= '0;
        end else if (state == ITER) begin
            mcandQ  <= mcandQ << STEP;
            mplierQ <= mplierQ >> STEP;
            clAccQ  <= clAccNext;
        end
    end
`endif

    always_comb begin
        iterRes = XLEN'(cntNext);
`ifdef ZBB_MC_ZBC_EN
        case (opQ)
            OP_CLMUL:  iterRes = clAccNext[XLEN-1:0];
            OP_CLMULH: iterRes = clAccNext[2*XLEN-1:XLEN];
            OP_CLMULR: iterRes = clAccNext[2*XLEN-2:XLEN-1];
            default:   iterRes = XLEN'(cntNext);
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (valid_i && !flush_i) stateNext = iterLegal ? ITER : DONE;
            ITER: begin
                if (flush_i)       stateNext = IDLE;
                else if (lastIter) stateNext = DONE;
            end
            DONE: if (flush_i || ready_i) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            respQ  <= '0;
            opQ    <= '0;
            shReg  <= '0;
            cntQ   <= '0;
            foundQ <= 1'b0;
            iterQ  <= '0;
        end else if (acceptIter) begin
            opQ    <= op_i;
            shReg  <= (op_i == OP_CTZ) ? rs1Rev : rs1_i;
            cntQ   <= '0;
            foundQ <= 1'b0;
            iterQ  <= '0;
        end else if (acceptSingle) begin
            respQ.data    <= singleLegal ? singleRes : '0;
            respQ.illegal <= !singleLegal;
        end else if (flush_i && state != IDLE) begin
            respQ <= '0;
        end else if (state == ITER) begin
            shReg  <= shReg << STEP;
            cntQ   <= cntNext;
            foundQ <= foundNext;
            iterQ  <= iterQ + IW'(1);
            if (lastIter) begin
                respQ.data    <= iterRes;
                respQ.illegal <= 1'b0;
            end
        end
    end

    assign ready_o   = (state == IDLE);
    assign valid_o   = (state == DONE);
    assign result_o  = respQ.data;
    assign illegal_o = respQ.illegal;

endmodule

// File: tb/tb_zbb_mc_unit.sv
// Directed bench for zbb_mc_unit: a 32/4 and a 64/8 instance driven in lockstep from shared stimulus.
module tb_zbb_mc_unit;
    logic        clk, rst_n, valid_i, flush_i, ready_i;
    logic [4:0]  op;
    logic [63:0] rs1, rs2;

    logic        rdy32, v32, ill32, rdy64, v64, ill64;
    logic [31:0] r32;
    logic [63:0] r64;

    int nTests = 0;
    int nFail  = 0;

    zbb_mc_unit #(.XLEN(32), .STEP(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(rdy32), .op_i(op),
        .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .flush_i(flush_i), .valid_o(v32),
        .ready_i(ready_i), .result_o(r32), .illegal_o(ill32)
    );

    zbb_mc_unit #(.XLEN(64), .STEP(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(rdy64), .op_i(op),
        .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush_i), .valid_o(v64),
        .ready_i(ready_i), .result_o(r64), .illegal_o(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b);
        op = o; rs1 = a; rs2 = b; valid_i = 1'b1;
        tick;
        valid_i = 1'b0;
    endtask

    task automatic waitValid(output int lat, output bit rdySeen);
        lat = 1;
        rdySeen = rdy32;
        while (!v32 && lat < 40) begin
            tick;
            lat++;
            if (rdy32) rdySeen = 1'b1;
        end
    endtask

    task automatic release_result;
        ready_i = 1'b1;
        tick;
        ready_i = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [4:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [31:0] exp32, input int expLat,
                         input bit chk64, input logic [63:0] exp64);
        int lat;
        bit rdySeen;
        issue(o, a, b);
        waitValid(lat, rdySeen);
        check({tag, "_lat"}, 64'(lat), 64'(expLat));
        check({tag, "_busy"}, 64'(rdySeen), 64'd0);
        check(tag, 64'(r32), 64'(exp32));
        check({tag, "_ill"}, 64'(ill32), 64'd0);
        if (chk64) check({tag, "_64"}, r64, exp64);
        release_result;
        check({tag, "_rdyAfter"}, 64'(rdy32), 64'd1);
    endtask

    initial begin
        int lat;
        bit rdySeen;
        int vSeen;

        rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        op = '0; rs1 = '0; rs2 = '0;
        tick; tick;
        rst_n = 1'b1;
        check("rst_ready", 64'(rdy32), 64'd1);
        check("rst_valid", 64'(v32), 64'd0);
        check("rst_result", 64'(r32), 64'd0);
        check("rst_illegal", 64'(ill32), 64'd0);
        check("rst_valid64", 64'(v64), 64'd0);
        tick;

        runOp("andn",  5'd0,  64'hF0F0F0F0, 64'hFF00FF00, 32'h00F000F0, 1, 0, 0);
        runOp("xnor",  5'd2,  64'hF0F0F0F0, 64'hFF00FF00, 32'hF00FF00F, 1, 0, 0);
        runOp("min",   5'd3,  64'hFFFFFFFF, 64'h1,        32'hFFFFFFFF, 1, 0, 0);
        runOp("max",   5'd4,  64'hFFFFFFFF, 64'h1,        32'h00000001, 1, 0, 0);
        runOp("minu",  5'd5,  64'hFFFFFFFF, 64'h1,        32'h00000001, 1, 0, 0);
        runOp("sextb", 5'd7,  64'h12345680, 64'h0,        32'hFFFFFF80, 1, 0, 0);
        runOp("rol",   5'd10, 64'h80000001, 64'h4,        32'h00000018, 1, 0, 0);
        runOp("orcb",  5'd12, 64'h00120003, 64'h0,        32'h00FF00FF, 1, 0, 0);
        runOp("rev8",  5'd13, 64'h11223344, 64'h0,        32'h44332211, 1, 0, 0);

        runOp("clz",   5'd16, 64'h00010000, 64'h0, 32'd15, 9, 0, 0);
        runOp("clz0",  5'd16, 64'h0,        64'h0, 32'd32, 9, 1, 64'd64);
        runOp("ctz",   5'd17, 64'h80000000, 64'h0, 32'd31, 9, 1, 64'd31);

        runOp("maxu64", 5'd6, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 32'hFFFFFFFF, 1, 1, 64'hFFFFFFFF_FFFFFFFF);

        issue(5'd15, 64'h1234, 64'h5678);
        waitValid(lat, rdySeen);
        check("ill15_lat", 64'(lat), 64'd1);
        check("ill15_flag", 64'(ill32), 64'd1);
        check("ill15_res", 64'(r32), 64'd0);
        release_result;

`ifdef ZBB_MC_ZBC_EN
        runOp("clmul",  5'd20, 64'h3,        64'h3, 32'h5, 9, 0, 0);
        runOp("clmulh", 5'd21, 64'h80000000, 64'h2, 32'h1, 9, 0, 0);
`else
        issue(5'd20, 64'h3, 64'h3);
        waitValid(lat, rdySeen);
        check("op20_lat", 64'(lat), 64'd1);
        check("op20_ill", 64'(ill32), 64'd1);
        check("op20_res", 64'(r32), 64'd0);
        release_result;
`endif

        // CPOP with a stalled consumer
        issue(5'd18, 64'hFFFFFFFF_FFFFFFFF, 64'h0);
        waitValid(lat, rdySeen);
        check("cpop_lat", 64'(lat), 64'd9);
        check("cpop_res", 64'(r32), 64'd32);
        check("cpop_res64", r64, 64'd64);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("cpop_holdV", 64'(v32), 64'd1);
            check("cpop_holdR", 64'(r32), 64'd32);
            check("cpop_holdRdy", 64'(rdy32), 64'd0);
        end
        release_result;
        check("cpop_rdyAfter", 64'(rdy32), 64'd1);
        check("cpop_vAfter", 64'(v32), 64'd0);

        // flush mid-iteration
        issue(5'd18, 64'hFFFFFFFF, 64'h0);
        tick; tick;
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        check("flush_rdy", 64'(rdy32), 64'd1);
        check("flush_v", 64'(v32), 64'd0);
        vSeen = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (v32) vSeen++;
        end
        check("flush_noValid", 64'(vSeen), 64'd0);

        // request presented with flush in IDLE is dropped
        op = 5'd0; rs1 = 64'h1; rs2 = 64'h0; valid_i = 1'b1; flush_i = 1'b1;
        tick;
        valid_i = 1'b0; flush_i = 1'b0;
        check("idleFlush_v", 64'(v32), 64'd0);
        check("idleFlush_rdy", 64'(rdy32), 64'd1);

        runOp("ror", 5'd11, 64'h1, 64'h1, 32'h80000000, 1, 0, 0);

        // reset mid-iteration
        issue(5'd16, 64'h00010000, 64'h0);
        tick; tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("midRst_v", 64'(v32), 64'd0);
        check("midRst_res", 64'(r32), 64'd0);
        check("midRst_rdy", 64'(rdy32), 64'd1);
        check("midRst_v64", 64'(v64), 64'd0);
        check("midRst_rdy64", 64'(rdy64), 64'd1);
        tick;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
